m_ij_qc_mem: RTL

- Parametrised check-to-variable message store for one QC-LDPC circulant block.
- Holds Z messages of W bits each, in a register array.
- Supports four operations:
  - serial initial load from the channel LLR path;
  - paired odd/even write-back from the node processors;
  - paired reads with a circulant shift applied;
  - serial dump of the final contents on decode completion.
- Sits between the variable-node and check-node update units inside the decoder core.

---
 rtl/m_ij_qc_mem.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/m_ij_qc_mem.sv
// Check-to-variable message store for one QC-LDPC circulant block: serial load,
// paired write-back, circulant-shifted paired reads and serial dump on completion.
module m_ij_qc_mem #(
  parameter int W     = 16,
  parameter int Z     = 16,
  parameter int SHIFT = 0,
  parameter int AW    = $clog2(Z)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_initial,
  input  logic [W-1:0] data_i_i,
  input  logic         we,
  input  logic [W-1:0] data_in_e,
  input  logic [W-1:0] data_in_o,
  input  logic         re,
  output logic [W-1:0] data_out_e,
  output logic [W-1:0] data_out_o,
  output logic         data_out_valid,
  input  logic         done,
  output logic [W-1:0] data_o_d,
  output logic         dump_valid,
  output logic         dump_last,
  output logic         load_done,
  output logic         busy
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(Z - 1);
  localparam logic [AW-2:0] LAST_PAIR = (AW-1)'(Z / 2 - 1);
  localparam logic [AW:0]   Z_EXT     = (AW+1)'(Z);
  localparam logic [AW:0]   SHIFT_EXT = (AW+1)'(SHIFT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  mem_r [Z];
  logic [AW-1:0] ld_ptr_r;
  logic [AW-1:0] dp_r;
  logic [AW-2:0] wp_r;
  logic [AW-2:0] rp_r;

  logic          do_dump_s;
  logic          do_load_s;
  logic          do_write_s;
  logic          do_read_s;
  logic [AW:0]   e_sum_s;
  logic [AW:0]   o_sum_s;
  logic [AW-1:0] e_idx_s;
  logic [AW-1:0] o_idx_s;
  logic [AW-1:0] wr_e_idx_s;
  logic [AW-1:0] wr_o_idx_s;

  // Operation arbitration (done > data_initial > we/re) and shifted read addressing
  always_comb begin
    do_dump_s  = done && (state_r != ST_DUMP);
    do_load_s  = !do_dump_s && data_initial && (state_r != ST_DUMP);
    do_write_s = (state_r == ST_IDLE) && !done && !data_initial && we;
    do_read_s  = (state_r == ST_IDLE) && !done && !data_initial && re;
    // Sums stay below 2*Z, so one conditional subtract gives the modulo
    e_sum_s    = {1'b0, rp_r, 1'b0} + SHIFT_EXT;
    o_sum_s    = {1'b0, rp_r, 1'b1} + SHIFT_EXT;
    if (e_sum_s >= Z_EXT) begin
      e_idx_s = AW'(e_sum_s - Z_EXT);
    end else begin
      e_idx_s = AW'(e_sum_s);
    end
    if (o_sum_s >= Z_EXT) begin
      o_idx_s = AW'(o_sum_s - Z_EXT);
    end else begin
      o_idx_s = AW'(o_sum_s);
    end
    wr_e_idx_s = {wp_r, 1'b0};
    wr_o_idx_s = {wp_r, 1'b1};
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (done) begin
          state_s = ST_DUMP;
        end else if (data_initial) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (done) begin
          state_s = ST_DUMP;
        end else if (data_initial && (ld_ptr_r == LAST_IDX)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DUMP: begin
        if (dump_last) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DUMP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Message array, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Z; i++) begin
        mem_r[i] <= '0;
      end
      ld_ptr_r       <= '0;
      dp_r           <= '0;
      wp_r           <= '0;
      rp_r           <= '0;
      data_out_e     <= '0;
      data_out_o     <= '0;
      data_out_valid <= 1'b0;
      data_o_d       <= '0;
      dump_valid     <= 1'b0;
      dump_last      <= 1'b0;
      load_done      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      load_done      <= 1'b0;
      data_out_valid <= 1'b0;
      busy           <= (state_s != ST_IDLE);
      if (do_dump_s) begin
        // First entry goes out on the edge that accepts done; any load in flight is dropped
        ld_ptr_r   <= '0;
        data_o_d   <= mem_r[0];
        dump_valid <= 1'b1;
        dump_last  <= 1'b0;
        dp_r       <= AW'(1);
      end else if (state_r == ST_DUMP) begin
        if (dump_last) begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          dp_r       <= '0;
        end else begin
          data_o_d   <= mem_r[dp_r];
          dump_valid <= 1'b1;
          dump_last  <= (dp_r == LAST_IDX);
          if (dp_r == LAST_IDX) begin
            dp_r <= '0;
          end else begin
            dp_r <= dp_r + AW'(1);
          end
        end
      end else begin
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
        if (do_load_s) begin
          mem_r[ld_ptr_r] <= data_i_i;
          if (ld_ptr_r == LAST_IDX) begin
            ld_ptr_r  <= '0;
            load_done <= 1'b1;
          end else begin
            ld_ptr_r <= ld_ptr_r + AW'(1);
          end
        end else begin
          if (do_write_s) begin
            mem_r[wr_e_idx_s] <= data_in_e;
            mem_r[wr_o_idx_s] <= data_in_o;
            if (wp_r == LAST_PAIR) begin
              wp_r <= '0;
            end else begin
              wp_r <= wp_r + (AW-1)'(1);
            end
          end else begin
            wp_r <= wp_r;
          end
          // Reading the array before this edge's writes land gives read-before-write
          if (do_read_s) begin
            data_out_e     <= mem_r[e_idx_s];
            data_out_o     <= mem_r[o_idx_s];
            data_out_valid <= 1'b1;
            if (rp_r == LAST_PAIR) begin
              rp_r <= '0;
            end else begin
              rp_r <= rp_r + (AW-1)'(1);
            end
          end else begin
            rp_r <= rp_r;
          end
        end
      end
    end
  end

endmodule
